// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Optional feature macro: DCACHE_STATS_EN (hit/miss counters on the top).
package dcache_pkg;
    localparam int OFFSET_W  = 5;
    localparam int INDEX_W   = 5;
    localparam int TAG_W     = 22;
    localparam int LINE_BITS = 256;
    localparam int WORD_W    = 32;

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_INSTALL   = 2'd3
    } state_e;

    // Pick one 32-bit word out of a line by its word index.
    function automatic logic [WORD_W-1:0] word_of(input line_t line, input logic [2:0] w);
        return line[{w, 5'b00000} +: WORD_W];
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag/data storage: asynchronous read, synchronous write, async clear of valid/dirty.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] idx_i,
    output logic               valid_o,
    output logic               dirty_o,
    output tag_t               tag_o,
    output line_t              line_o,
    input  logic               fill_we_i,
    input  tag_t               fill_tag_i,
    input  line_t              fill_line_i,
    input  logic               word_we_i,
    input  logic [2:0]         word_sel_i,
    input  logic [WORD_W-1:0]  word_data_i
);
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    tag_t                 tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // Next valid/dirty: install makes the line clean, a store hit dirties it.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_we_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end else if (word_we_i) begin
            dirty_d[idx_i] = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Valid/dirty flags, cleared asynchronously so every line misses after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays: whole-line install or single-word store merge.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b00000} +: WORD_W] <= word_data_i;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Optional macro DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);
    state_e state_q, state_d;
    line_t  line_q, line_d;

    logic [INDEX_W-1:0] idx_s;
    logic [2:0]         word_s;
    tag_t               req_tag_s;
    logic               req_s, hit_s;
    logic               v_valid_s, v_dirty_s;
    tag_t               v_tag_s;
    line_t              v_line_s;
    logic               unused_s;

    assign idx_s     = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign word_s    = cpu_addr_i[4:2];
    assign req_tag_s = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign unused_s  = ^cpu_addr_i[1:0];

    assign req_s = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit_s = v_valid_s & (v_tag_s == req_tag_s);

    // Loads see the word in the same cycle; misses and idle cycles return zero.
    assign cpu_data_o  = (req_s & hit_s) ? word_of(v_line_s, word_s) : 32'd0;
    assign cpu_stall_o = (req_s & ~hit_s) | (state_q != ST_IDLE);

    dcache_sram #(.NUM_LINES(NUM_LINES)) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (idx_s),
        .valid_o     (v_valid_s),
        .dirty_o     (v_dirty_s),
        .tag_o       (v_tag_s),
        .line_o      (v_line_s),
        .fill_we_i   (state_q == ST_INSTALL),
        .fill_tag_i  (req_tag_s),
        .fill_line_i (line_q),
        .word_we_i   ((state_q == ST_IDLE) & cpu_MemWrite_i & hit_s),
        .word_sel_i  (word_s),
        .word_data_i (cpu_data_i)
    );

    // Miss sequencing; the refill buffer is captured only on a REFILL ack.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s & ~hit_s) begin
                    state_d = (v_valid_s & v_dirty_s) ? ST_WRITEBACK : ST_REFILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = ST_REFILL;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_REFILL: begin
                if (mem_ack_i) begin
                    line_d  = mem_data_i;
                    state_d = ST_INSTALL;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_INSTALL: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register and refill buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
        end
    end

    // Memory-side outputs decoded from the registered state only.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {v_tag_s, idx_s, 5'b00000};
                mem_data_o   = v_line_s;
            end
            ST_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag_s, idx_s, 5'b00000};
            end
            default: begin
                mem_enable_o = 1'b0;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        post_install_q, post_install_d;

    // Count real hits (not the completion cycle after an install) and miss starts.
    always_comb begin
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        post_install_d = (state_q == ST_INSTALL);
        if ((state_q == ST_IDLE) & req_s & hit_s & ~post_install_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if ((state_q == ST_IDLE) & req_s & ~hit_s) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q      <= 32'd0;
            miss_cnt_q     <= 32'd0;
            post_install_q <= 1'b0;
        end else begin
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            post_install_q <= post_install_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule
